// File: rtl/simmem_rank_scheduler.sv
// rtl/simmem_rank_scheduler.sv - single-rank timing scheduler with open-row model
//
// Picks one pending beat per idle cycle from the write and read slots, models
// the open row buffer and the rank busy counter, pulses done a fixed lead time
// before the rank frees, and drives the free-running request timestamp.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   w_req_valid_i/addr/ts  per-write-slot pending beat, address, arrival stamp
//   r_req_valid_i/addr/ts  per-read-slot pending beat, address, arrival stamp
//   w/r_grant_onehot_o   one-cycle combinational grant to the winning slot
//   w/r_done_onehot_o    one-cycle completion pulse to the granted slot
//   busy_o               rank counter running
//   row_open_o, open_row_o  open row buffer state
//   now_o                free-running timestamp
module simmem_rank_scheduler #(
  parameter int unsigned NumWSlots      = 6,
  parameter int unsigned NumRSlots      = 6,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned RowBufLenWidth = 8,
  parameter int unsigned TimestampWidth = 8,
  parameter int unsigned DelayWidth     = 8,
  parameter int unsigned RowHitCost     = 10,
  parameter int unsigned ActivationCost = 20,
  parameter int unsigned PrechargeCost  = 30,
  parameter int unsigned DoneLead       = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumWSlots-1:0]                  w_req_valid_i,
  input  logic [NumWSlots*AddrWidth-1:0]        w_req_addr_i,
  input  logic [NumWSlots*TimestampWidth-1:0]   w_req_ts_i,
  input  logic [NumRSlots-1:0]                  r_req_valid_i,
  input  logic [NumRSlots*AddrWidth-1:0]        r_req_addr_i,
  input  logic [NumRSlots*TimestampWidth-1:0]   r_req_ts_i,
  output logic [NumWSlots-1:0]                  w_grant_onehot_o,
  output logic [NumRSlots-1:0]                  r_grant_onehot_o,
  output logic [NumWSlots-1:0]                  w_done_onehot_o,
  output logic [NumRSlots-1:0]                  r_done_onehot_o,
  output logic                                  busy_o,
  output logic                                  row_open_o,
  output logic [AddrWidth-RowBufLenWidth-1:0]   open_row_o,
  output logic [TimestampWidth-1:0]             now_o
);

  localparam int unsigned RowW    = AddrWidth - RowBufLenWidth;
  localparam int unsigned MaxCost = RowHitCost + ActivationCost + PrechargeCost;

  localparam logic [DelayWidth-1:0] CostHit  = DelayWidth'(RowHitCost);
  localparam logic [DelayWidth-1:0] CostAct  = DelayWidth'(RowHitCost + ActivationCost);
  localparam logic [DelayWidth-1:0] CostPre  = DelayWidth'(MaxCost);
  localparam logic [DelayWidth-1:0] LeadCnt  = DelayWidth'(DoneLead);
  localparam logic [DelayWidth-1:0] OneCnt   = DelayWidth'(1);

  if (MaxCost > (2**DelayWidth) - 1) begin : g_cost_width_check
    $error("largest access cost does not fit in DelayWidth");
  end
  if (DoneLead < 1 || DoneLead >= RowHitCost) begin : g_lead_range_check
    $error("DoneLead must lie in 1..RowHitCost-1");
  end

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [DelayWidth-1:0]   cnt_q, cnt_d;
  logic [TimestampWidth-1:0] now_q;
  logic                    row_open_q;
  logic [RowW-1:0]         open_row_q;
  logic [NumWSlots-1:0]    pend_w_q;
  logic [NumRSlots-1:0]    pend_r_q;
  logic                    load;

  // Arbitration result
  logic                    sel_found;
  logic [DelayWidth-1:0]   sel_cost;
  logic [TimestampWidth-1:0] sel_age;
  logic [RowW-1:0]         sel_row;
  logic [NumWSlots-1:0]    sel_w_oh;
  logic [NumRSlots-1:0]    sel_r_oh;
  logic [DelayWidth-1:0]   cand_cost;
  logic [TimestampWidth-1:0] cand_age;
  logic [RowW-1:0]         cand_row;
  logic                    unused_addr_lo;

  function automatic logic [DelayWidth-1:0] cost_of(
    input logic [RowW-1:0] row,
    input logic            is_open,
    input logic [RowW-1:0] cur_row
  );
    if (!is_open) return CostAct;
    if (row == cur_row) return CostHit;
    return CostPre;
  endfunction

  // Reads are scanned first and a later candidate only replaces the current
  // pick when strictly cheaper or strictly older, so ties fall to reads and
  // then to the lowest slot index without extra compare terms.
  always_comb begin
    sel_found = 1'b0;
    sel_cost  = '0;
    sel_age   = '0;
    sel_row   = '0;
    sel_w_oh  = '0;
    sel_r_oh  = '0;
    cand_cost = '0;
    cand_age  = '0;
    cand_row  = '0;
    for (int i = 0; i < NumRSlots; i++) begin
      if (r_req_valid_i[i]) begin
        cand_row  = r_req_addr_i[i*AddrWidth + RowBufLenWidth +: RowW];
        cand_cost = cost_of(cand_row, row_open_q, open_row_q);
        cand_age  = now_q - r_req_ts_i[i*TimestampWidth +: TimestampWidth];
        if (!sel_found || cand_cost < sel_cost ||
            (cand_cost == sel_cost && cand_age > sel_age)) begin
          sel_found   = 1'b1;
          sel_cost    = cand_cost;
          sel_age     = cand_age;
          sel_row     = cand_row;
          sel_w_oh    = '0;
          sel_r_oh    = '0;
          sel_r_oh[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NumWSlots; i++) begin
      if (w_req_valid_i[i]) begin
        cand_row  = w_req_addr_i[i*AddrWidth + RowBufLenWidth +: RowW];
        cand_cost = cost_of(cand_row, row_open_q, open_row_q);
        cand_age  = now_q - w_req_ts_i[i*TimestampWidth +: TimestampWidth];
        if (!sel_found || cand_cost < sel_cost ||
            (cand_cost == sel_cost && cand_age > sel_age)) begin
          sel_found   = 1'b1;
          sel_cost    = cand_cost;
          sel_age     = cand_age;
          sel_row     = cand_row;
          sel_w_oh    = '0;
          sel_r_oh    = '0;
          sel_w_oh[i] = 1'b1;
        end
      end
    end
  end

  // Byte-offset bits never influence scheduling.
  always_comb begin
    unused_addr_lo = 1'b0;
    for (int i = 0; i < NumWSlots; i++) begin
      unused_addr_lo = unused_addr_lo ^ (^w_req_addr_i[i*AddrWidth +: RowBufLenWidth]);
    end
    for (int i = 0; i < NumRSlots; i++) begin
      unused_addr_lo = unused_addr_lo ^ (^r_req_addr_i[i*AddrWidth +: RowBufLenWidth]);
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    load             = 1'b0;
    w_grant_onehot_o = '0;
    r_grant_onehot_o = '0;
    w_done_onehot_o  = '0;
    r_done_onehot_o  = '0;
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          w_grant_onehot_o = sel_w_oh;
          r_grant_onehot_o = sel_r_oh;
          cnt_d            = sel_cost;
          load             = 1'b1;
          state_d          = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - OneCnt;
        if (cnt_q == LeadCnt) begin
          w_done_onehot_o = pend_w_q;
          r_done_onehot_o = pend_r_q;
        end
        if (cnt_q == OneCnt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      now_q      <= '0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      pend_w_q   <= '0;
      pend_r_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      now_q   <= now_q + TimestampWidth'(1);
      if (load) begin
        row_open_q <= 1'b1;
        open_row_q <= sel_row;
        pend_w_q   <= sel_w_oh;
        pend_r_q   <= sel_r_oh;
      end
    end
  end

  assign busy_o     = (state_q == StBusy);
  assign row_open_o = row_open_q;
  assign open_row_o = open_row_q;
  assign now_o      = now_q;

endmodule

// File: tb/tb_simmem_rank_scheduler.sv
// tb/tb_simmem_rank_scheduler.sv - self-checking bench for simmem_rank_scheduler
module tb_simmem_rank_scheduler;

  localparam int NW = 6, NR = 6, AW = 32, RB = 8, TW = 8, DW = 8;
  localparam int HIT = 10, ACT = 20, PRE = 30, LEAD = 3;
  localparam int RW = AW - RB;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NW-1:0]    w_valid;
  logic [NW*AW-1:0] w_addr;
  logic [NW*TW-1:0] w_ts;
  logic [NR-1:0]    r_valid;
  logic [NR*AW-1:0] r_addr;
  logic [NR*TW-1:0] r_ts;
  logic [NW-1:0]    w_grant, w_done;
  logic [NR-1:0]    r_grant, r_done;
  logic             busy, row_open;
  logic [RW-1:0]    open_row;
  logic [TW-1:0]    now;

  simmem_rank_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n),
    .w_req_valid_i(w_valid), .w_req_addr_i(w_addr), .w_req_ts_i(w_ts),
    .r_req_valid_i(r_valid), .r_req_addr_i(r_addr), .r_req_ts_i(r_ts),
    .w_grant_onehot_o(w_grant), .r_grant_onehot_o(r_grant),
    .w_done_onehot_o(w_done), .r_done_onehot_o(r_done),
    .busy_o(busy), .row_open_o(row_open), .open_row_o(open_row), .now_o(now)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: absolute cycle bookkeeping instead of a countdown.
  int cyc, m_now, m_open_row, m_free_at, m_done_at, m_done_kind, m_done_idx;
  bit m_row_open;
  int g_kind, g_idx, g_cost, g_age, g_row;

  // Values seen at the last sampled cycle
  logic [NW-1:0] seen_wg, seen_wd;
  logic [NR-1:0] seen_rg, seen_rd;
  logic seen_busy;
  int s_cyc;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_cost(input int row);
    if (!m_row_open) return HIT + ACT;
    if (row == m_open_row) return HIT;
    return HIT + ACT + PRE;
  endfunction

  // Cheapest, then oldest, then read (kind 1) over write, then lowest index.
  task automatic model_pick();
    int row, cost, age, ts;
    bit v, better;
    g_kind = -1; g_idx = 0; g_cost = 0; g_age = 0; g_row = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) begin
        v   = (k == 0) ? w_valid[i] : r_valid[i];
        row = (k == 0) ? int'(w_addr[i*AW +: AW] >> RB) : int'(r_addr[i*AW +: AW] >> RB);
        ts  = (k == 0) ? int'(w_ts[i*TW +: TW]) : int'(r_ts[i*TW +: TW]);
        if (v) begin
          cost = model_cost(row);
          age  = (m_now - ts + 256) % 256;
          better = (g_kind < 0) || (cost < g_cost) ||
                   (cost == g_cost && (age > g_age ||
                   (age == g_age && (k > g_kind || (k == g_kind && i < g_idx)))));
          if (better) begin
            g_kind = k; g_idx = i; g_cost = cost; g_age = age; g_row = row;
          end
        end
      end
    end
  endtask

  task automatic step();
    logic [NW-1:0] ew, edw;
    logic [NR-1:0] er, edr;
    bit m_busy;
    @(negedge clk);
    model_pick();
    m_busy = (cyc < m_free_at);
    ew = '0; er = '0; edw = '0; edr = '0;
    if (!m_busy && g_kind == 0) ew[g_idx] = 1'b1;
    if (!m_busy && g_kind == 1) er[g_idx] = 1'b1;
    if (cyc == m_done_at && m_done_kind == 0) edw[m_done_idx] = 1'b1;
    if (cyc == m_done_at && m_done_kind == 1) edr[m_done_idx] = 1'b1;
    chk("w_grant", w_grant, ew);
    chk("r_grant", r_grant, er);
    chk("w_done", w_done, edw);
    chk("r_done", r_done, edr);
    chk("busy", busy, m_busy);
    chk("row_open", row_open, m_row_open);
    chk("open_row", open_row, m_open_row);
    chk("now", now, m_now);
    seen_wg = w_grant; seen_rg = r_grant; seen_wd = w_done; seen_rd = r_done;
    seen_busy = busy; s_cyc = cyc;
    @(posedge clk);
    if (!m_busy && g_kind >= 0) begin
      m_row_open = 1'b1; m_open_row = g_row;
      m_free_at = cyc + g_cost + 1;
      m_done_at = cyc + g_cost - LEAD + 1;
      m_done_kind = g_kind; m_done_idx = g_idx;
    end
    cyc++;
    m_now = (m_now + 1) % 256;
    #1;
  endtask

  task automatic clear_inputs();
    w_valid = '0; r_valid = '0; w_addr = '0; r_addr = '0; w_ts = '0; r_ts = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rst_w_grant", w_grant, 0);
    chk("rst_r_grant", r_grant, 0);
    chk("rst_w_done", w_done, 0);
    chk("rst_r_done", r_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row_open", row_open, 0);
    chk("rst_open_row", open_row, 0);
    chk("rst_now", now, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0; m_now = 0; m_row_open = 1'b0; m_open_row = 0;
    m_free_at = 0; m_done_at = -1; m_done_kind = 0; m_done_idx = 0;
  endtask

  // what: 0 = any grant, 1 = any done, 2 = rank idle
  task automatic wait_for(input int what, input int maxc, output int at);
    at = -1;
    for (int k = 0; k < maxc && at < 0; k++) begin
      step();
      if ((what == 0 && (seen_wg != 0 || seen_rg != 0)) ||
          (what == 1 && (seen_wd != 0 || seen_rd != 0)) ||
          (what == 2 && !seen_busy)) at = s_cyc;
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL wait_for%0d: no event within %0d cycles", what, maxc);
    end
  endtask

  typedef struct {
    int now;
    logic [5:0]  wv, rv;
    logic [47:0] wts, rts;
    logic [5:0]  ew, er;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int gc, ic, dc, gr, gw, ndone;
    vecs[0] = '{20, 6'b000100, 6'b010000, 48'h0000_0005_0000, 48'h0009_0000_0000, 6'b000100, 6'b000000};
    vecs[1] = '{10, 6'b000010, 6'b000010, 48'h0000_0000_0300, 48'h0000_0000_0300, 6'b000000, 6'b000010};
    vecs[2] = '{10, 6'b000000, 6'b101000, 48'h0000_0000_0000, 48'h0300_0300_0000, 6'b000000, 6'b001000};
    vecs[3] = '{4,  6'b000001, 6'b000001, 48'h0000_0000_00FA, 48'h0000_0000_0002, 6'b000001, 6'b000000};
    vecs[4] = '{4,  6'b000000, 6'b100100, 48'h0000_0000_0000, 48'hFA00_0002_0000, 6'b000000, 6'b100000};
    vecs[5] = '{7,  6'b100000, 6'b000001, 48'h0000_0000_0000, 48'h0000_0000_0001, 6'b100000, 6'b000000};
    vecs[6] = '{3,  6'b111111, 6'b111111, 48'h0000_0000_0000, 48'h0000_0000_0000, 6'b000000, 6'b000001};

    clear_inputs();
    #2;
    // Single read from reset, then row hit beats a precharge.
    do_reset();
    r_valid[0] = 1'b1; r_addr[0 +: AW] = 32'h100;
    wait_for(0, 5, gc);
    chk("seq1_grant_cycle", gc, 0);
    chk("seq1_grant_slot", seen_rg, 6'b000001);
    clear_inputs();
    wait_for(1, 40, dc);
    chk("seq1_done_cycle", dc, 28);
    wait_for(2, 40, ic);
    chk("seq1_idle_cycle", ic, 31);
    chk("seq1_open_row", open_row, 1);
    r_valid[1] = 1'b1; r_addr[1*AW +: AW] = 32'h1F0;
    w_valid[0] = 1'b1; w_addr[0 +: AW] = 32'h500;
    wait_for(0, 5, gr);
    chk("seq2_read_first", seen_rg, 6'b000010);
    r_valid = '0;
    wait_for(0, 40, gw);
    chk("seq2_write_next", seen_wg, 6'b000001);
    chk("seq2_read_cost", gw - gr - 1, 10);
    w_valid = '0;
    wait_for(2, 80, ic);
    chk("seq2_write_cost", ic - gw - 1, 60);

    // Arbitration table, each from reset with no row open.
    foreach (vecs[n]) begin
      do_reset();
      for (int k = 0; k < 300 && cyc < vecs[n].now; k++) step();
      w_valid = vecs[n].wv; r_valid = vecs[n].rv;
      w_ts = vecs[n].wts; r_ts = vecs[n].rts;
      for (int i = 0; i < 6; i++) begin
        w_addr[i*AW +: AW] = 32'h1000 + 32'(i) * 32'h100;
        r_addr[i*AW +: AW] = 32'h2000 + 32'(i) * 32'h100;
      end
      step();
      gc = s_cyc;
      chk($sformatf("vec%0d_w_grant", n), seen_wg, vecs[n].ew);
      chk($sformatf("vec%0d_r_grant", n), seen_rg, vecs[n].er);
      clear_inputs();
      wait_for(2, 60, ic);
      chk($sformatf("vec%0d_cost", n), ic - gc - 1, 30);
    end

    // Reset while the rank counter is at 15 drops the operation.
    do_reset();
    r_valid[0] = 1'b1; r_addr[0 +: AW] = 32'h300;
    wait_for(0, 5, gc);
    clear_inputs();
    for (int k = 0; k < 40 && (m_free_at - cyc) != 15; k++) step();
    chk("midrst_cnt_reached", m_free_at - cyc, 15);
    do_reset();
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (seen_wd != 0 || seen_rd != 0) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    w_valid[3] = 1'b1; w_addr[3*AW +: AW] = 32'h700;
    wait_for(0, 5, gc);
    chk("midrst_grant_slot", seen_wg, 6'b001000);
    clear_inputs();
    wait_for(2, 60, ic);
    chk("midrst_cost", ic - gc - 1, 30);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 6; i++) begin
        w_valid[i] = ($urandom_range(0, 3) == 0);
        r_valid[i] = ($urandom_range(0, 3) == 0);
        w_addr[i*AW +: AW] = {22'd0, 2'($urandom_range(0, 3)), 8'($urandom)};
        r_addr[i*AW +: AW] = {22'd0, 2'($urandom_range(0, 3)), 8'($urandom)};
        w_ts[i*TW +: TW] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(m_now - $urandom_range(0, 12));
        r_ts[i*TW +: TW] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(m_now - $urandom_range(0, 12));
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simmem_rank_scheduler.md
Name: simmem_rank_scheduler

Overview:
- Single-rank timing scheduler for the simulated memory controller.
- Each cycle it sees one candidate burst beat per write slot and per read slot. When the rank is idle it grants the cheapest candidate: row hit first, then oldest, then reads over writes, then lowest index.
- It models the open row buffer and the rank busy counter. It emits a one-hot done pulse a programmable lead time before the rank frees, so the response banks can release in time.
- It also drives the free-running timestamp that the slot logic stamps on incoming requests.

Parameters:
NumWSlots, 6, number of write slots
NumRSlots, 6, number of read slots
AddrWidth, 32, global memory address width
RowBufLenWidth, 8, log2 of row buffer length in bytes; row id = addr[AddrWidth-1:RowBufLenWidth]
TimestampWidth, 8, width of timestamps and of now_o
DelayWidth, 8, width of costs and of the rank counter
RowHitCost, 10, cycles for an access to the open row
ActivationCost, 20, extra cycles to activate a row
PrechargeCost, 30, extra cycles to close a different open row
DoneLead, 3, cycles of lead between the done pulse and the rank freeing; legal range 1..RowHitCost-1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
w_req_valid_i  in  NumWSlots  write slot i presents a pending beat
w_req_addr_i  in  NumWSlots*AddrWidth  beat addresses, slot i at [i*AddrWidth +: AddrWidth]
w_req_ts_i  in  NumWSlots*TimestampWidth  slot arrival timestamps
r_req_valid_i  in  NumRSlots  read slot i presents a pending beat
r_req_addr_i  in  NumRSlots*AddrWidth  read beat addresses
r_req_ts_i  in  NumRSlots*TimestampWidth  read slot timestamps
w_grant_onehot_o  out  NumWSlots  one-cycle grant pulse to a write slot
r_grant_onehot_o  out  NumRSlots  one-cycle grant pulse to a read slot
w_done_onehot_o  out  NumWSlots  one-cycle completion pulse to the granted write slot
r_done_onehot_o  out  NumRSlots  one-cycle completion pulse to the granted read slot
busy_o  out  1  rank counter non-zero
row_open_o  out  1  a row is open
open_row_o  out  AddrWidth-RowBufLenWidth  id of the open row
now_o  out  TimestampWidth  free-running timestamp

Behaviour:
- Reset (async, rst_ni=0):
  - Grant and done outputs are 0.
  - busy_o=0, row_open_o=0, open_row_o=0, now_o=0.
  - The pending-grant record is cleared.
  - Any in-flight operation is dropped; no done pulse is issued for it.
- now_o increments every cycle and wraps modulo 2^TimestampWidth.
- Cost of a candidate:
  - RowHitCost if row open and its row id equals open_row_o.
  - RowHitCost+ActivationCost if no row is open.
  - RowHitCost+ActivationCost+PrechargeCost otherwise.
  - Elaboration check: the largest cost fits in DelayWidth.
- Age of a candidate = (now_o - ts) mod 2^TimestampWidth. Larger age means older.
- FSM IDLE/BUSY; busy_o = (state==BUSY).
- In IDLE with at least one valid candidate:
  - Selection order: min cost, then max age, then read over write, then lowest slot index.
  - The grant pulse is combinational in that same cycle T.
  - Registers load: cnt_q<=cost, row_open<=1, open_row<=row id of the winner, pending<=winner one-hot and kind.
  - Next state BUSY.
- In IDLE with no valid candidate: no grant, and state holds.
- In BUSY:
  - cnt_q decrements by 1 each cycle; requests are ignored and no grants are issued.
  - When cnt_q==DoneLead, the done pulse fires on the pending slot for exactly one cycle.
  - When cnt_q==1, the next state is IDLE.
- Timing for a grant at cycle T with cost C:
  - Done pulse at T+C-DoneLead+1.
  - IDLE at T+C+1, where a new grant can issue; back-to-back grants are separated by C+1 cycles.
- Requester rules:
  - A requester may withdraw valid before it is granted.
  - After a grant it must present its next beat, or deassert, by the next IDLE cycle.
- The row is never closed except by reset. Precharge is modelled only as a cost.

Test Plan:
- Reset, then a single read at addr 0x100: r_grant[0] at cycle 0 with cost 30. done at cycle 28, busy_o low at cycle 31, open_row=0x1.
- After the above, read 0x1F0 (row 0x1) and write 0x500 (row 0x5) are both valid: the read is granted with cost 10; the write follows with cost 60.
- Equal-cost write in slot 2 (ts=5) and read in slot 4 (ts=9), now=20: the write wins on age.
- Equal cost and equal ts across write slot 1 and read slot 1: the read wins. With two reads in slots 3 and 5, slot 3 wins.
- ts=250 vs ts=2 with now=4 (wrap): ts=250 is older (age 10 vs 2) and is granted.
- Assert rst_ni low while cnt_q=15: all outputs clear immediately, no done pulse is ever issued, and the first grant after reset has cost 30.
